// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular trace of ROB-head commits, frozen a fixed
// number of commits after a mispredict, then drained oldest-first.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   commit_*        ROB head commit event (valid, pc, pc_next, order, inst,
//                   mispredict)
//   arm             starts a capture session when the buffer is idle
//   drain_*         valid/ready read port for frozen entries
//   count           number of valid entries held
//   state           00 idle, 01 armed, 10 post-trigger, 11 frozen
//   dropped         saturating count of entries overwritten this session
module commit_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_pc_next,
  input  logic [63:0]              commit_order,
  input  logic [31:0]              commit_inst,
  input  logic                     commit_mispredict,
  input  logic                     arm,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [31:0]              drain_pc,
  output logic [31:0]              drain_pc_next,
  output logic [63:0]              drain_order,
  output logic [31:0]              drain_inst,
  output logic                     drain_mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic [15:0]              dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    POST   = 2'b10,
    FROZEN = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t          mem [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] post_q;
  logic [15:0]   drop_q;
  logic          cap;
  logic          full;
  logic          pop;
  ent_t          head;

  assign cap  = commit_valid &&
                (state_q == ARMED || state_q == POST);
  assign full = (cnt_q == CW'(DEPTH));
  assign drain_valid = (state_q == FROZEN) && (cnt_q != '0);
  assign pop  = drain_valid && drain_ready;
  assign head = drain_valid ? mem[rd_q] : '0;

  assign drain_pc         = head.pc;
  assign drain_pc_next    = head.pc_next;
  assign drain_order      = head.order;
  assign drain_inst       = head.inst;
  assign drain_mispredict = head.mis;
  assign count            = cnt_q;
  assign state            = state_q;
  assign dropped          = drop_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (arm) state_d = ARMED;
      ARMED:
        if (commit_valid && commit_mispredict)
          state_d = (POST_TRIG == 0) ? FROZEN : POST;
      POST:
        if (commit_valid && post_q == CW'(1))
          state_d = FROZEN;
      FROZEN:
        if (cnt_q == '0 || (pop && cnt_q == CW'(1)))
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      post_q <= '0;
      drop_q <= '0;
    end else if (state_q == IDLE && arm) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      post_q <= '0;
      drop_q <= '0;
    end else if (cap) begin
      wr_q <= wr_q + PW'(1);
      // Full buffer: newest entry evicts the oldest.
      if (full) begin
        rd_q <= rd_q + PW'(1);
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ARMED && commit_mispredict)
        post_q <= CW'(POST_TRIG);
      else if (state_q == POST)
        post_q <= post_q - CW'(1);
    end else if (pop) begin
      rd_q  <= rd_q + PW'(1);
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wr_q] <= '{
        pc:      commit_pc,
        pc_next: commit_pc_next,
        order:   commit_order,
        inst:    commit_inst,
        mis:     commit_mispredict
      };
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue-based reference
// model; two instances cover the zero and nonzero post-trigger cases.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0;
  logic [31:0] cpc = '0;
  logic [31:0] cpcn = '0;
  logic [63:0] cord = '0;
  logic [31:0] cinst = '0;
  logic        cmis = 1'b0;
  logic        arm = 1'b0;
  logic        rdy = 1'b0;

  logic        d0_v, d1_v, d0_m, d1_m;
  logic [31:0] d0_pc, d1_pc, d0_pn, d1_pn, d0_in, d1_in;
  logic [63:0] d0_or, d1_or;
  logic [4:0]  d0_c, d1_c;
  logic [1:0]  d0_s, d1_s;
  logic [15:0] d0_d, d1_d;

  logic        o_v, o_m;
  logic [31:0] o_pc, o_pn, o_in;
  logic [63:0] o_or;
  logic [4:0]  o_c;
  logic [1:0]  o_s;
  logic [15:0] o_d;

  int   sel = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ent_t        mq[$];
  logic [1:0]  mstate = 2'b00;
  int          mpost = 0;
  int          mdrop = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .commit_valid(cv), .commit_pc(cpc),
    .commit_pc_next(cpcn), .commit_order(cord), .commit_inst(cinst),
    .commit_mispredict(cmis), .arm(arm), .drain_valid(d0_v),
    .drain_ready(rdy), .drain_pc(d0_pc), .drain_pc_next(d0_pn),
    .drain_order(d0_or), .drain_inst(d0_in), .drain_mispredict(d0_m),
    .count(d0_c), .state(d0_s), .dropped(d0_d)
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(4)) dut1 (
    .clk(clk), .rst(rst), .commit_valid(cv), .commit_pc(cpc),
    .commit_pc_next(cpcn), .commit_order(cord), .commit_inst(cinst),
    .commit_mispredict(cmis), .arm(arm), .drain_valid(d1_v),
    .drain_ready(rdy), .drain_pc(d1_pc), .drain_pc_next(d1_pn),
    .drain_order(d1_or), .drain_inst(d1_in), .drain_mispredict(d1_m),
    .count(d1_c), .state(d1_s), .dropped(d1_d)
  );

  always_comb begin
    o_v  = (sel != 0) ? d1_v  : d0_v;
    o_m  = (sel != 0) ? d1_m  : d0_m;
    o_pc = (sel != 0) ? d1_pc : d0_pc;
    o_pn = (sel != 0) ? d1_pn : d0_pn;
    o_in = (sel != 0) ? d1_in : d0_in;
    o_or = (sel != 0) ? d1_or : d0_or;
    o_c  = (sel != 0) ? d1_c  : d0_c;
    o_s  = (sel != 0) ? d1_s  : d0_s;
    o_d  = (sel != 0) ? d1_d  : d0_d;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".state"}, 64'(o_s), 64'(mstate));
    chk({tag, ".count"}, 64'(o_c), 64'(mq.size()));
    chk({tag, ".dropped"}, 64'(o_d), 64'(mdrop));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    mstate = 2'b00;
    mpost = 0;
    mdrop = 0;
    chk_regs("reset");
    chk("reset.drain_valid", 64'(o_v), 64'd0);
  endtask

  // One clock: drive inputs, check drain port before the edge,
  // advance the model, then check registered outputs.
  task automatic cyc(input logic a, input logic v, input logic m,
                     input logic [31:0] pc, input logic [63:0] ord,
                     input logic r, input string tag);
    int pt;
    logic ev;
    ent_t e;
    pt = (sel != 0) ? 4 : 0;
    arm = a; cv = v; cmis = m; rdy = r;
    cpc = pc; cpcn = pc + 32'd4; cord = ord;
    cinst = ord[31:0] ^ 32'h00A5_0013;
    #1;
    ev = (mstate == 2'b11) && (mq.size() != 0);
    chk({tag, ".drain_valid"}, 64'(o_v), 64'(ev));
    if (ev) begin
      chk({tag, ".drain_pc"}, 64'(o_pc), 64'(mq[0].pc));
      chk({tag, ".drain_pc_next"}, 64'(o_pn), 64'(mq[0].pc_next));
      chk({tag, ".drain_order"}, o_or, mq[0].order);
      chk({tag, ".drain_inst"}, 64'(o_in), 64'(mq[0].inst));
      chk({tag, ".drain_mis"}, 64'(o_m), 64'(mq[0].mis));
    end else begin
      chk({tag, ".drain_zero"}, {o_pc, o_in}, 64'd0);
    end
    @(posedge clk); #1;
    unique case (mstate)
      2'b00: if (a) begin
        mq.delete(); mdrop = 0; mpost = 0; mstate = 2'b01;
      end
      2'b01, 2'b10: if (v) begin
        e = '{pc, pc + 32'd4, ord, ord[31:0] ^ 32'h00A5_0013, m};
        mq.push_back(e);
        if (mq.size() > DEPTH) begin
          void'(mq.pop_front());
          if (mdrop < 16'hFFFF) mdrop++;
        end
        if (mstate == 2'b01 && m) begin
          if (pt == 0) mstate = 2'b11;
          else begin mstate = 2'b10; mpost = pt; end
        end else if (mstate == 2'b10) begin
          mpost--;
          if (mpost == 0) mstate = 2'b11;
        end
      end
      default: begin
        if (mq.size() == 0) mstate = 2'b00;
        else if (r) begin
          void'(mq.pop_front());
          if (mq.size() == 0) mstate = 2'b00;
        end
      end
    endcase
    chk_regs(tag);
    arm = 1'b0; cv = 1'b0; cmis = 1'b0; rdy = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 2 * DEPTH + 4 && mstate == 2'b11; i++)
      cyc(0, 0, 0, 0, 0, 1, tag);
    chk({tag, ".idle_after"}, 64'(o_s), 64'd0);
  endtask

  initial begin
    // Trigger on the third commit, no post-trigger window.
    sel = 0;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "t1.arm");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, i == 2, 32'h1000 + 32'(4 * i), 64'(i), 0, "t1.cm");
    chk("t1.frozen", 64'(o_s), 64'd3);
    chk("t1.count3", 64'(o_c), 64'd3);
    drain_all("t1.dr");

    // Overflow: 20 commits, trigger at 15, 4 more after.
    sel = 1;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "t2.arm");
    for (int i = 0; i < 20; i++)
      cyc(0, 1, i == 15, 32'h2000 + 32'(4 * i), 64'(i), 0, "t2.cm");
    chk("t2.frozen", 64'(o_s), 64'd3);
    chk("t2.count16", 64'(o_c), 64'd16);
    chk("t2.dropped4", 64'(o_d), 64'd4);
    chk("t2.first_order", o_or, 64'd4);
    drain_all("t2.dr");

    // Second mispredict inside the window must not retrigger,
    // then drain with stalls and ignored commits.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "t3.arm");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, i == 5 || i == 7, 32'h3000 + 32'(4 * i), 64'(i), 0,
          "t3.cm");
    chk("t3.frozen", 64'(o_s), 64'd3);
    chk("t3.count10", 64'(o_c), 64'd10);
    for (int i = 0; i < 40 && mstate == 2'b11; i++)
      cyc(0, (i % 3) == 1, 0, 32'hDEAD_0000, 64'd99, (i % 3) != 1,
          "t4.dr");
    chk("t4.idle", 64'(o_s), 64'd0);

    // Reset in the middle of the post-trigger window.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "t5.arm");
    for (int i = 0; i < 7; i++)
      cyc(0, 1, i == 3, 32'h5000 + 32'(4 * i), 64'(i), 0, "t5.cm");
    chk("t5.post", 64'(o_s), 64'd2);
    chk("t5.count7", 64'(o_c), 64'd7);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "t5.rearm");
    chk("t5.dropped0", 64'(o_d), 64'd0);

    // arm and drain_ready while armed change nothing on their own.
    cyc(1, 0, 0, 0, 0, 1, "t6.idle");
    cyc(1, 1, 0, 32'h6000, 64'd0, 1, "t6.cm0");
    cyc(0, 0, 0, 0, 0, 1, "t6.idle2");
    cyc(1, 1, 0, 32'h6004, 64'd1, 1, "t6.cm1");
    chk("t6.armed", 64'(o_s), 64'd1);
    chk("t6.count2", 64'(o_c), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable on-chip trace buffer that captures ROB-head commit events into a circular store.
- Once armed, it records every committed instruction (pc, pc_next, order, inst, mispredict flag).
- After a committed branch mispredict it captures POST_TRIG more commits, then freezes.
- Frozen contents drain oldest-first over a valid/ready port to a debug/perf reader.
- Sits beside the ROB commit path and is fed from the same head-entry signals the RRF consumes.

Parameters:
- DEPTH, 16, number of trace entries; power of 2, at least 2.
- POST_TRIG, 4, commits captured after the trigger commit before freezing; 0 to DEPTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- commit_valid  input  1  ROB head commits this cycle
- commit_pc  input  32  PC of committing instruction
- commit_pc_next  input  32  architectural next PC
- commit_order  input  64  rvfi order of committing instruction
- commit_inst  input  32  instruction word
- commit_mispredict  input  1  committing instruction was a mispredicted branch/jump
- arm  input  1  start a capture session (honoured only in IDLE)
- drain_valid  output  1  oldest entry available
- drain_ready  input  1  reader accepts entry
- drain_pc  output  32  entry field
- drain_pc_next  output  32  entry field
- drain_order  output  64  entry field
- drain_inst  output  32  entry field
- drain_mispredict  output  1  entry field
- count  output  $clog2(DEPTH)+1  valid entries held
- state  output  2  00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
- dropped  output  16  entries overwritten this session, saturating

Behaviour:
- Reset: state=IDLE, count=0, dropped=0, rd/wr pointers=0, post counter=0, drain_valid=0, drain_* = 0. Storage contents need not be cleared.
- rst asserted in any state aborts the session; buffered entries are lost.
- IDLE:
  - No capture.
  - arm=1 -> ARMED next cycle; count, dropped and pointers cleared in the same edge.
- ARMED:
  - Each commit_valid writes one entry at wr_ptr; wr_ptr++ (mod DEPTH).
  - If count<DEPTH, count++.
  - If count==DEPTH, the oldest entry is overwritten: rd_ptr++, count stays DEPTH, dropped++ (saturates at 0xFFFF).
  - A commit with commit_mispredict=1 is captured, then:
    - POST_TRIG=0 -> FROZEN;
    - otherwise -> POST with post counter=POST_TRIG.
- POST:
  - Captures exactly as in ARMED.
  - Each captured commit decrements the post counter; the commit that takes it 1->0 is captured and the state moves to FROZEN.
  - Further mispredicts do not retrigger.
- FROZEN:
  - No capture; commit_valid ignored.
  - drain_valid = (count!=0).
  - drain_* driven combinationally from entry[rd_ptr]; drain_* = 0 when drain_valid=0.
  - drain_valid & drain_ready -> rd_ptr++, count--.
  - The handshake that takes count 1->0 -> IDLE next cycle.
  - FROZEN with count==0 (not reachable normally) -> IDLE.
- arm outside IDLE is ignored.
- drain_ready outside FROZEN is ignored; drain_valid stays 0.
- Capture latency: a commit at edge N is visible at count/state after edge N. An entry is drainable the cycle after FROZEN is entered.
- count, state and dropped are registered outputs; entry order is strictly commit order.

Test Plan:
- Reset, then arm; 3 commits (pc 0x1000, 0x1004, 0x1008, order 0..2), 3rd with mispredict, POST_TRIG=0 -> state=11, count=3; drain with ready=1 yields pc 0x1000, 0x1004, 0x1008 in 3 cycles, drain_mispredict only on the 3rd, then state=00.
- DEPTH=16, POST_TRIG=4: 20 commits (order 0..19), mispredict on order 15 -> freezes after order 19; count=16, dropped=4, first drained order=4, last=19.
- Mispredict at order 5 and again at order 7 with POST_TRIG=4 -> freeze after order 9 (no retrigger); count=10.
- FROZEN with drain_ready toggling 1,0,1: drain_* holds the same entry while ready=0; commit_valid pulses during FROZEN leave count unchanged.
- rst asserted mid-POST with count=7 -> state=00, count=0, drain_valid=0; a subsequent arm starts with dropped=0.
- arm pulsed in ARMED, and drain_ready held high in ARMED -> no state change, count still increments on commits only.
